// File: rtl/dma_csr_pkg.sv
// Register offsets, bit positions and engine states shared by the MM2S CSR bank.
package dma_csr_pkg;

    localparam int REG_DMACR  = 'h00;
    localparam int REG_DMASR  = 'h04;
    localparam int REG_SA     = 'h18;
    localparam int REG_LENGTH = 'h28;

    localparam int BIT_RS         = 0;
    localparam int BIT_RESET      = 2;
    localparam int BIT_IOC_IRQ_EN = 12;
    localparam int BIT_HALTED     = 0;
    localparam int BIT_IDLE       = 1;
    localparam int BIT_IOC_IRQ    = 12;

    typedef enum logic [1:0] {
        ST_HALTED,
        ST_IDLE,
        ST_CMD,
        ST_BUSY
    } eng_state_t;

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite channel handshakes: one write (AW+W together) or read in flight per channel.
// Read data returns one cycle after the AR handshake; B and R hold until bready/rready.
module axil_slave_if #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data
);

    assign wr_en   = awready & awvalid & wvalid;
    assign wr_addr = awaddr;
    assign wr_data = wdata;
    assign rd_en   = arready & arvalid;
    assign rd_addr = araddr;
    assign wready  = awready;
    assign bresp   = 2'b00;
    assign rresp   = 2'b00;

    // Ready pulses for a single cycle, so each accepted request yields exactly one response.
    always_ff @(posedge clk) begin
        if (rst) begin
            awready <= 1'b0;
            bvalid  <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            awready <= awvalid & wvalid & ~bvalid & ~awready;
            if (wr_en)
                bvalid <= 1'b1;
            else if (bready)
                bvalid <= 1'b0;
            arready <= arvalid & ~rvalid & ~arready;
            if (rd_en) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dma_csr_axil.sv
// MM2S DMA control/status registers: a nonzero LENGTH write in IDLE issues one command,
// held on cmd_valid until cmd_ready; cmd_done sets IOC and returns to IDLE or HALTED.
module dma_csr_axil
    import dma_csr_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] S_AXI_LITE_awaddr,
    input  logic              S_AXI_LITE_awvalid,
    output logic              S_AXI_LITE_awready,
    input  logic [31:0]       S_AXI_LITE_wdata,
    input  logic              S_AXI_LITE_wvalid,
    output logic              S_AXI_LITE_wready,
    output logic [1:0]        S_AXI_LITE_bresp,
    output logic              S_AXI_LITE_bvalid,
    input  logic              S_AXI_LITE_bready,
    input  logic [ADDR_W-1:0] S_AXI_LITE_araddr,
    input  logic              S_AXI_LITE_arvalid,
    output logic              S_AXI_LITE_arready,
    output logic [31:0]       S_AXI_LITE_rdata,
    output logic [1:0]        S_AXI_LITE_rresp,
    output logic              S_AXI_LITE_rvalid,
    input  logic              S_AXI_LITE_rready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [31:0]       cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_done,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr, wr_word, rd_word;
    logic [31:0]       wr_data, rd_data;
    logic              wr_dmacr, wr_dmasr, wr_sa, wr_len, start;
    logic              rs, ioc_en, ioc, soft_rst;
    logic [31:0]       sa;
    logic [LEN_W-1:0]  len;
    eng_state_t        state;

    axil_slave_if #(.ADDR_W(ADDR_W)) u_if (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (S_AXI_LITE_awaddr),
        .awvalid (S_AXI_LITE_awvalid),
        .awready (S_AXI_LITE_awready),
        .wdata   (S_AXI_LITE_wdata),
        .wvalid  (S_AXI_LITE_wvalid),
        .wready  (S_AXI_LITE_wready),
        .bresp   (S_AXI_LITE_bresp),
        .bvalid  (S_AXI_LITE_bvalid),
        .bready  (S_AXI_LITE_bready),
        .araddr  (S_AXI_LITE_araddr),
        .arvalid (S_AXI_LITE_arvalid),
        .arready (S_AXI_LITE_arready),
        .rdata   (S_AXI_LITE_rdata),
        .rresp   (S_AXI_LITE_rresp),
        .rvalid  (S_AXI_LITE_rvalid),
        .rready  (S_AXI_LITE_rready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign wr_word  = wr_addr & WORD_MASK;
    assign rd_word  = rd_addr & WORD_MASK;
    assign wr_dmacr = wr_en && (wr_word == ADDR_W'(REG_DMACR));
    assign wr_dmasr = wr_en && (wr_word == ADDR_W'(REG_DMASR));
    assign wr_sa    = wr_en && (wr_word == ADDR_W'(REG_SA));
    assign wr_len   = wr_en && (wr_word == ADDR_W'(REG_LENGTH));
    assign start    = wr_len && (state == ST_IDLE) && (wr_data[LEN_W-1:0] != '0);

    // The soft reset strobe lives outside the register reset so it clears itself.
    always_ff @(posedge clk) begin
        if (rst)
            soft_rst <= 1'b0;
        else
            soft_rst <= wr_dmacr & wr_data[BIT_RESET];
    end

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            state     <= ST_HALTED;
            rs        <= 1'b0;
            ioc_en    <= 1'b0;
            ioc       <= 1'b0;
            sa        <= '0;
            len       <= '0;
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_dmacr) begin
                rs     <= wr_data[BIT_RS];
                ioc_en <= wr_data[BIT_IOC_IRQ_EN];
            end
            if (wr_sa)
                sa <= wr_data;
            if (wr_len)
                len <= wr_data[LEN_W-1:0];
            // Completion beats a same-cycle write-1-to-clear.
            if (state == ST_BUSY && cmd_done)
                ioc <= 1'b1;
            else if (wr_dmasr && wr_data[BIT_IOC_IRQ])
                ioc <= 1'b0;
            irq <= ioc & ioc_en;

            case (state)
                ST_HALTED: if (rs) state <= ST_IDLE;
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_CMD;
                        cmd_valid <= 1'b1;
                        cmd_addr  <= sa;
                        cmd_len   <= wr_data[LEN_W-1:0];
                    end else if (!rs) begin
                        state <= ST_HALTED;
                    end
                end
                ST_CMD: begin
                    if (cmd_ready) begin
                        state     <= ST_BUSY;
                        cmd_valid <= 1'b0;
                    end
                end
                ST_BUSY: if (cmd_done) state <= rs ? ST_IDLE : ST_HALTED;
                default: state <= ST_HALTED;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (rd_word)
                ADDR_W'(REG_DMACR): begin
                    rd_data[BIT_RS]         = rs;
                    rd_data[BIT_IOC_IRQ_EN] = ioc_en;
                end
                ADDR_W'(REG_DMASR): begin
                    rd_data[BIT_HALTED]  = (state == ST_HALTED);
                    rd_data[BIT_IDLE]    = (state == ST_IDLE);
                    rd_data[BIT_IOC_IRQ] = ioc;
                end
                ADDR_W'(REG_SA):     rd_data = sa;
                ADDR_W'(REG_LENGTH): rd_data[LEN_W-1:0] = len;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_csr_axil.sv
// Scoreboard bench for dma_csr_axil: expected reads and commands are queued at issue, compared on completion.
module tb_dma_csr_axil;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 26;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [ADDR_W-1:0] araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [31:0]       cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_done = 1'b0;
    logic              irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;

    typedef struct {
        logic [31:0]      addr;
        logic [LEN_W-1:0] len;
    } cmd_exp_t;

    rd_exp_t  rd_q[$];
    cmd_exp_t cmd_q[$];
    int checks   = 0;
    int failures = 0;

    dma_csr_axil #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .S_AXI_LITE_awaddr  (awaddr),
        .S_AXI_LITE_awvalid (awvalid),
        .S_AXI_LITE_awready (awready),
        .S_AXI_LITE_wdata   (wdata),
        .S_AXI_LITE_wvalid  (wvalid),
        .S_AXI_LITE_wready  (wready),
        .S_AXI_LITE_bresp   (bresp),
        .S_AXI_LITE_bvalid  (bvalid),
        .S_AXI_LITE_bready  (bready),
        .S_AXI_LITE_araddr  (araddr),
        .S_AXI_LITE_arvalid (arvalid),
        .S_AXI_LITE_arready (arready),
        .S_AXI_LITE_rdata   (rdata),
        .S_AXI_LITE_rresp   (rresp),
        .S_AXI_LITE_rvalid  (rvalid),
        .S_AXI_LITE_rready  (rready),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .cmd_done           (cmd_done),
        .irq                (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic axil_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit with_done = 1'b0);
        int n = 0;
        @(negedge clk);
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(awready && wready) && n < 20);
        check("aw_w_handshake", 32'(awready & wready), 32'd1);
        if (!(awready && wready)) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            return;
        end
        if (with_done) cmd_done = 1'b1;
        @(negedge clk);
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        cmd_done = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
    endtask

    task automatic axil_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag, input int stall = 0);
        int n = 0;
        rd_exp_t e;
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 20);
        check({tag, "_ar"}, 32'(arready), 32'd1);
        if (!arready) begin
            arvalid = 1'b0;
            return;
        end
        e.tag = tag;
        e.exp = exp;
        rd_q.push_back(e);
        @(negedge clk);
        arvalid = 1'b0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        if (!rvalid) begin
            e = rd_q.pop_front();
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold_vld"}, 32'(rvalid), 32'd1);
            check({tag, "_hold_dat"}, rdata, exp);
        end
        rready = 1'b1;
        e = rd_q.pop_front();
        check(e.tag, rdata, e.exp);
        check({e.tag, "_rresp"}, 32'(rresp), 32'd0);
        @(negedge clk);
        rready = 1'b0;
        check({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
    endtask

    task automatic expect_cmd(input logic [31:0] a, input logic [LEN_W-1:0] l);
        cmd_exp_t e;
        e.addr = a;
        e.len  = l;
        cmd_q.push_back(e);
    endtask

    task automatic accept_cmd();
        int n = 0;
        cmd_exp_t e;
        while (!cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_valid", 32'(cmd_valid), 32'd1);
        check("cmd_pending", 32'(cmd_q.size()), 32'd1);
        if (cmd_q.size() > 0) begin
            e = cmd_q.pop_front();
            check("cmd_addr", cmd_addr, e.addr);
            check("cmd_len", 32'(cmd_len), 32'(e.len));
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("cmd_valid_drop", 32'(cmd_valid), 32'd0);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_handshakes", 32'({awready, wready, arready, bvalid, rvalid, cmd_valid, irq}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_cmd_addr", cmd_addr, 32'd0);
        check("rst_cmd_len", 32'(cmd_len), 32'd0);
        rst = 1'b0;

        axil_read(10'h04, 32'h0000_0001, "sr_reset", 3);
        axil_read(10'h00, 32'h0000_0000, "cr_reset");
        axil_write(10'h00, 32'h0000_1001);
        axil_read(10'h04, 32'h0000_0002, "sr_idle");
        axil_read(10'h00, 32'h0000_1001, "cr_rb");

        // First command, held off by cmd_ready for five cycles.
        axil_write(10'h18, 32'h1000_0000);
        expect_cmd(32'h1000_0000, LEN_W'(32'h400));
        axil_write(10'h28, 32'h0000_0400);
        check("cmd_valid_n1", 32'(cmd_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cmd_hold_vld", 32'(cmd_valid), 32'd1);
            check("cmd_hold_addr", cmd_addr, 32'h1000_0000);
            check("cmd_hold_len", 32'(cmd_len), 32'h400);
        end
        accept_cmd();
        axil_read(10'h04, 32'h0000_0000, "sr_busy");
        pulse_done();
        check("irq_m1", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_m2", 32'(irq), 32'd1);
        axil_read(10'h04, 32'h0000_1002, "sr_ioc");
        axil_write(10'h04, 32'h0000_1000);
        check("irq_w1c_1", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_w1c_2", 32'(irq), 32'd0);
        axil_read(10'h04, 32'h0000_0002, "sr_cleared");

        // LENGTH write while busy only updates the register.
        expect_cmd(32'h1000_0000, LEN_W'(32'h200));
        axil_write(10'h28, 32'h0000_0200);
        accept_cmd();
        axil_write(10'h28, 32'h0000_0080);
        repeat (3) @(negedge clk);
        check("no_second_cmd", 32'(cmd_valid), 32'd0);
        axil_read(10'h28, 32'h0000_0080, "len_busy_rb");
        pulse_done();
        axil_read(10'h04, 32'h0000_1002, "sr_done2");
        axil_write(10'h04, 32'h0000_1000);

        // Zero length never starts a command.
        axil_write(10'h28, 32'h0000_0000);
        repeat (3) @(negedge clk);
        check("len0_no_cmd", 32'(cmd_valid), 32'd0);
        axil_read(10'h04, 32'h0000_0002, "sr_len0_idle");
        axil_read(10'h28, 32'h0000_0000, "len0_rb");

        // Completion and W1C on the same edge: the set wins.
        expect_cmd(32'h1000_0000, LEN_W'(32'h40));
        axil_write(10'h28, 32'h0000_0040);
        accept_cmd();
        axil_write(10'h04, 32'h0000_1000, 1'b1);
        axil_read(10'h04, 32'h0000_1002, "sr_set_wins");
        axil_write(10'h04, 32'h0000_1000);

        // RS cleared mid-command: command completes, then the engine halts.
        expect_cmd(32'h1000_0000, LEN_W'(32'h20));
        axil_write(10'h28, 32'h0000_0020);
        axil_write(10'h00, 32'h0000_1000);
        check("cmd_hold_rs0", 32'(cmd_valid), 32'd1);
        accept_cmd();
        pulse_done();
        axil_read(10'h04, 32'h0000_1001, "sr_halted_after");
        axil_write(10'h04, 32'h0000_1000);
        pulse_done();
        axil_read(10'h04, 32'h0000_0001, "done_ignored");

        // Unmapped addresses and SA readback.
        axil_write(10'h3C, 32'hDEAD_BEEF);
        axil_read(10'h3C, 32'h0000_0000, "unmapped");
        axil_read(10'h18, 32'h1000_0000, "sa_rb");

        // Soft reset during BUSY.
        axil_write(10'h00, 32'h0000_1001);
        axil_write(10'h18, 32'h0000_2000);
        expect_cmd(32'h0000_2000, LEN_W'(32'h10));
        axil_write(10'h28, 32'h0000_0010);
        accept_cmd();
        axil_write(10'h00, 32'h0000_0004);
        @(negedge clk);
        check("srst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("srst_irq", 32'(irq), 32'd0);
        check("srst_cmd_addr", cmd_addr, 32'd0);
        check("srst_cmd_len", 32'(cmd_len), 32'd0);
        axil_read(10'h04, 32'h0000_0001, "srst_sr");
        axil_read(10'h00, 32'h0000_0000, "srst_cr");
        axil_read(10'h18, 32'h0000_0000, "srst_sa");
        axil_read(10'h28, 32'h0000_0000, "srst_len");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
